// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between control logic and the ALU command sequencer.
// master = command source / response sink, slave = the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int unsigned TAG_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO, drives the external 4-bit logic ALU, waits a settle time,
// captures and checks the result, and returns it on a valid/ready response port.
module alu_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic                alu_s1,
  output logic                alu_s0,
  input  logic [3:0]          alu_out,
  output logic [7:0]          err_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [PtrW:0]    PtrOne = 1;
  localparam logic [CntW-1:0]  CntOne = 1;
  localparam logic [TAG_W-1:0] TagOne = 1;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO (extra pointer bit distinguishes full from empty)
  // ---------------------------------------------------------------------------
  cmd_t          mem_q [FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic          rst_n_q;
  cmd_t          head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign bus.cmd_ready = rst_n_q && !fifo_full;
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign head = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rst_n_q  <= 1'b0;
    end else begin
      rst_n_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM and registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [1:0]       alu_s_q, alu_s_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [3:0]       rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [3:0]       exp_res;
  logic             mismatch;

  // Expected result is derived from what is actually on the ALU inputs.
  always_comb begin
    exp_res = '0;
    unique case (alu_s_q)
      2'b00:   exp_res = alu_a_q & alu_b_q;
      2'b01:   exp_res = alu_a_q | alu_b_q;
      2'b10:   exp_res = alu_a_q ^ alu_b_q;
      2'b11:   exp_res = ~alu_a_q;
      default: exp_res = '0;
    endcase
  end

  assign mismatch = (alu_out != exp_res);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_tag_d   = rsp_tag_q;
    err_cnt_d   = err_cnt_q;
    pop         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          alu_a_d = head.a;
          alu_b_d = head.b;
          alu_s_d = head.op;
          cnt_d   = CntW'(SETTLE_CYC - 1);
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          rsp_data_d  = alu_out;
          rsp_err_d   = mismatch;
          rsp_valid_d = 1'b1;
          if (mismatch && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_tag_d   = rsp_tag_q + TagOne;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tag_q   <= rsp_tag_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_s1        = alu_s_q[1];
  assign alu_s0        = alu_s_q[0];
  assign err_count     = err_cnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tag   = rsp_tag_q;

endmodule
